// File: rtl/dd_pkg.sv
// rtl/dd_pkg.sv - shared GPIF scheduler state encoding and default timing constants
package dd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST,
        ST_GAP,
        ST_SHORT
    } state_t;

    localparam int DEF_BURST_LEN  = 1024;
    localparam int DEF_LEVEL_W    = 11;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_WM_TAIL    = 2;

endpackage

// File: rtl/gpif_burst_scheduler_if.sv
// rtl/gpif_burst_scheduler_if.sv - FIFO read port and FX3 thread-0 pins seen by the scheduler
interface gpif_burst_scheduler_if #(
    parameter int LEVEL_W = dd_pkg::DEF_LEVEL_W
);
    import dd_pkg::*;

    logic               capture_enable;
    logic               fx3_th0Ready;
    logic               fx3_th0Wmark;
    logic [LEVEL_W-1:0] fifo_level;
    logic               fifo_full;
    logic               fifo_read;
    logic               fx3_nWrite;
    logic               fx3_nShort;
    logic               fx3_nError;
    logic [15:0]        burst_count;
    logic               busy;

    // Environment side: FIFO, FX3 flags and run control
    modport master (
        output capture_enable, fx3_th0Ready, fx3_th0Wmark, fifo_level, fifo_full,
        input  fifo_read, fx3_nWrite, fx3_nShort, fx3_nError, burst_count, busy
    );

    // Scheduler side
    modport slave (
        input  capture_enable, fx3_th0Ready, fx3_th0Wmark, fifo_level, fifo_full,
        output fifo_read, fx3_nWrite, fx3_nShort, fx3_nError, burst_count, busy
    );

endinterface

// File: rtl/gpif_word_counter.sv
// rtl/gpif_word_counter.sv - loadable down-counter with terminal-count flag
module gpif_word_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_count,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    // Load wins over decrement; the count parks at zero so tc stays asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/gpif_burst_scheduler.sv
// rtl/gpif_burst_scheduler.sv - GPIF-II write burst sequencer from FIFO read side into FX3 thread 0
module gpif_burst_scheduler
    import dd_pkg::*;
#(
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LEVEL_W    = DEF_LEVEL_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int WM_TAIL    = DEF_WM_TAIL
) (
    input  logic                   fx3_clock,
    input  logic                   fx3_reset,
    gpif_burst_scheduler_if.slave  gpif
);
    localparam int                 CNT_W        = $clog2(BURST_LEN);
    localparam logic [LEVEL_W-1:0] LVL_BURST    = LEVEL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   LD_BURST     = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]   LD_SHORT_MAX = CNT_W'(BURST_LEN - 2);
    localparam logic [CNT_W-1:0]   LD_GAP       = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LD_TAIL      = CNT_W'(WM_TAIL - 1);
    localparam logic [CNT_W-1:0]   TAIL_WORDS   = CNT_W'(WM_TAIL);

    state_t       r_state;
    logic         r_strobe;
    logic         r_nshort;
    logic         r_nerror;
    logic         r_busy;
    logic         r_tail;
    logic         r_ready_q;
    logic [15:0]  r_burst_count;

    logic             w_cnt_load;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt_value;
    logic [CNT_W-1:0] w_count;
    logic             w_tc;
    logic             w_start_burst;
    logic             w_level_zero;
    logic             w_wm_hit;
    logic [CNT_W-1:0] w_short_load;

    // The counter value is "words left after the current one", so tc marks the last word
    gpif_word_counter #(.W(CNT_W)) u_word_counter (
        .clk     (fx3_clock),
        .rst     (fx3_reset),
        .i_load  (w_cnt_load),
        .i_en    (w_cnt_en),
        .i_value (w_cnt_value),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    assign w_level_zero  = (gpif.fifo_level == '0);
    assign w_start_burst = !r_ready_q && (gpif.fifo_level >= LVL_BURST);
    // A short packet never fills a whole DMA buffer, otherwise FX3 would not see it as short
    assign w_short_load  = (gpif.fifo_level >= LVL_BURST) ? LD_SHORT_MAX
                                                          : CNT_W'(gpif.fifo_level - LEVEL_W'(1));
    // A watermark with no more than WM_TAIL words left just lets the burst finish normally
    assign w_wm_hit      = !gpif.fx3_th0Wmark && !r_tail && (w_count > TAIL_WORDS);

    // Counter loads at every phase entry and counts down inside BURST, SHORT and GAP
    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_value = '0;
        case (r_state)
            ST_ARM: begin
                if (w_start_burst) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = LD_BURST;
                end else if (!gpif.capture_enable && !w_level_zero) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = w_short_load;
                end
            end
            ST_BURST: begin
                if (w_tc) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = LD_GAP;
                end else if (w_wm_hit) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = LD_TAIL;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_SHORT: begin
                if (w_tc) begin
                    w_cnt_load  = 1'b1;
                    w_cnt_value = LD_GAP;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_GAP:  w_cnt_en = 1'b1;
            default: w_cnt_en = 1'b0;
        endcase
    end

    // Burst FSM with registered strobe, short flag, sticky error, burst counter and busy
    always_ff @(posedge fx3_clock or posedge fx3_reset) begin
        if (fx3_reset) begin
            r_state       <= ST_IDLE;
            r_strobe      <= 1'b0;
            r_nshort      <= 1'b1;
            r_nerror      <= 1'b1;
            r_busy        <= 1'b0;
            r_tail        <= 1'b0;
            r_ready_q     <= 1'b1;
            r_burst_count <= '0;
        end else begin
            // Thread-ready is registered once before gating a burst start
            r_ready_q <= gpif.fx3_th0Ready;
            if ((r_state != ST_IDLE) && gpif.fifo_full) begin
                r_nerror <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (gpif.capture_enable) begin
                        r_state       <= ST_ARM;
                        r_busy        <= 1'b1;
                        r_burst_count <= '0;
                        // An overflow on the arming cycle still counts against the new run
                        r_nerror      <= !gpif.fifo_full;
                    end
                end
                ST_ARM: begin
                    if (w_start_burst) begin
                        r_state  <= ST_BURST;
                        r_strobe <= 1'b1;
                        r_tail   <= 1'b0;
                    end else if (!gpif.capture_enable) begin
                        if (!w_level_zero) begin
                            r_state  <= ST_SHORT;
                            r_strobe <= 1'b1;
                            r_nshort <= (gpif.fifo_level != LEVEL_W'(1));
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_tc) begin
                        r_state  <= ST_GAP;
                        r_strobe <= 1'b0;
                        if (!r_tail) begin
                            r_burst_count <= r_burst_count + 16'd1;
                        end
                    end else if (w_wm_hit) begin
                        r_tail <= 1'b1;
                    end
                end
                ST_SHORT: begin
                    if (w_tc) begin
                        r_state  <= ST_GAP;
                        r_strobe <= 1'b0;
                        r_nshort <= 1'b1;
                    end else if (w_count == CNT_W'(1)) begin
                        r_nshort <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_tc) begin
                        r_state <= ST_ARM;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_strobe <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign gpif.fifo_read   = r_strobe;
    assign gpif.fx3_nWrite  = !r_strobe;
    assign gpif.fx3_nShort  = r_nshort;
    assign gpif.fx3_nError  = r_nerror;
    assign gpif.burst_count = r_burst_count;
    assign gpif.busy        = r_busy;

endmodule

// File: tb/tb_gpif_burst_scheduler.sv
// tb/tb_gpif_burst_scheduler.sv - self-checking bench for gpif_burst_scheduler
module tb_gpif_burst_scheduler;
    localparam int BL      = 1024;
    localparam int LW      = 11;
    localparam int GAPC    = 4;
    localparam int TAIL    = 2;
    localparam int LVL_MAX = 2047;
    localparam int BETWEEN = GAPC + 1;
    localparam int BUDGET  = 3000;

    logic fx3_clock = 1'b0;
    logic fx3_reset = 1'b0;

    gpif_burst_scheduler_if #(.LEVEL_W(LW)) gpif ();

    gpif_burst_scheduler #(
        .BURST_LEN  (BL),
        .LEVEL_W    (LW),
        .GAP_CYCLES (GAPC),
        .WM_TAIL    (TAIL)
    ) dut (
        .fx3_clock (fx3_clock),
        .fx3_reset (fx3_reset),
        .gpif      (gpif)
    );

    always #5 fx3_clock = ~fx3_clock;

    int n_checks = 0;
    int n_errors = 0;

    int run = 0, short_at = 0, idle_run = 0, had_run = 0, wm_at = 0;
    int runs[$];
    int shorts[$];
    int gaps[$];
    int lvl = 0, fill = 0;
    int bad_pair = 0, short_stray = 0, underflow = 0;
    int exp_bc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int run_at(input int idx);
        return (idx < runs.size()) ? runs[idx] : -1;
    endfunction

    function automatic int short_of(input int idx);
        return (idx < shorts.size()) ? shorts[idx] : -1;
    endfunction

    task automatic set_level(input int v);
        lvl = v;
        gpif.fifo_level = LW'(v);
    endtask

    // One clock: observe at the falling edge, track strobe runs, then model the FIFO level
    task automatic cyc();
        @(negedge fx3_clock);
        if (!fx3_reset) begin
            if (gpif.fifo_read !== !gpif.fx3_nWrite) bad_pair++;
            if (gpif.fx3_nShort === 1'b0 && gpif.fx3_nWrite !== 1'b0) short_stray++;
            if (gpif.fx3_nWrite === 1'b0) begin
                if (lvl == 0) underflow++;
                if (run == 0 && had_run != 0) gaps.push_back(idle_run);
                run++;
                if (gpif.fx3_nShort === 1'b0) short_at = run;
                if (lvl > 0) lvl--;
            end else begin
                if (run != 0) begin
                    runs.push_back(run);
                    shorts.push_back(short_at);
                    run = 0;
                    short_at = 0;
                    idle_run = 0;
                    had_run = 1;
                    wm_at = 0;
                    gpif.fx3_th0Wmark = 1'b1;
                end
                idle_run++;
            end
            if (wm_at != 0 && run == wm_at) gpif.fx3_th0Wmark = 1'b0;
            lvl = lvl + fill;
            if (lvl > LVL_MAX) lvl = LVL_MAX;
            gpif.fifo_level = LW'(lvl);
        end
    endtask

    task automatic wait_runs(input int target, input string tag);
        int n = 0;
        while (runs.size() < target && n < BUDGET) begin
            cyc();
            n++;
        end
        check_eq(tag, runs.size() >= target, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (gpif.busy !== 1'b0 && n < BUDGET) begin
            cyc();
            n++;
        end
        check_eq(tag, gpif.busy, 0);
    endtask

    task automatic wait_strobe(output int lat);
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (run == 0 && lat < 50);
    endtask

    initial begin
        int lat, k, v, base, exp_len, n;
        int short_vals[4];

        gpif.capture_enable = 1'b0;
        gpif.fx3_th0Ready   = 1'b1;
        gpif.fx3_th0Wmark   = 1'b1;
        gpif.fifo_level     = '0;
        gpif.fifo_full      = 1'b0;

        #2 fx3_reset = 1'b1;
        #1;
        check_eq("rst_fifo_read",   gpif.fifo_read,   0);
        check_eq("rst_nWrite",      gpif.fx3_nWrite,  1);
        check_eq("rst_nShort",      gpif.fx3_nShort,  1);
        check_eq("rst_nError",      gpif.fx3_nError,  1);
        check_eq("rst_burst_count", gpif.burst_count, 0);
        check_eq("rst_busy",        gpif.busy,        0);
        @(negedge fx3_clock);
        @(negedge fx3_clock);
        fx3_reset = 1'b0;
        cyc();

        // Full burst from an enable rise, back-to-back bursts, ready rising mid-burst
        set_level(BL);
        fill = 1;
        gpif.fx3_th0Ready = 1'b0;
        cyc();
        gpif.capture_enable = 1'b1;
        exp_bc = 0;
        wait_strobe(lat);
        check_eq("s1_first_strobe_latency", lat, 2);
        check_eq("s1_busy", gpif.busy, 1);
        wait_runs(1, "s1_burst1_done");
        exp_bc++;
        check_eq("s1_burst1_len", run_at(0), BL);
        check_eq("s1_burst1_count", gpif.burst_count, exp_bc);
        wait_strobe(lat);
        check_eq("s1_gap_len", gaps.size() > 0 ? gaps[gaps.size()-1] : -1, BETWEEN);
        gpif.fx3_th0Ready = 1'b1;
        wait_runs(2, "s1_burst2_done");
        exp_bc++;
        check_eq("s1_burst2_len", run_at(1), BL);
        check_eq("s1_burst2_count", gpif.burst_count, exp_bc);
        fill = 0;

        // Thread not ready holds off a full FIFO; release starts the burst
        set_level(LVL_MAX);
        repeat (40) cyc();
        check_eq("s2_held_off_runs", runs.size(), 2);
        check_eq("s2_held_off_busy", gpif.busy, 1);
        gpif.fx3_th0Ready = 1'b0;
        wait_strobe(lat);
        check_eq("s2_ready_latency", lat, 2);
        wait_runs(3, "s2_burst_done");
        exp_bc++;
        check_eq("s2_burst_len", run_at(2), BL);
        check_eq("s2_burst_count", gpif.burst_count, exp_bc);

        // Watermark early exit: words = min(k + tail, burst); only full bursts count
        for (int i = 0; i < 3; i++) begin
            k = (i == 0) ? 500 : (i == 1) ? int'($urandom_range(1, BL - TAIL - 2)) : BL - 1;
            base = runs.size();
            set_level(1500);
            wm_at = k;
            wait_runs(base + 1, "s3_wm_done");
            exp_len = (k + TAIL < BL) ? k + TAIL : BL;
            if (exp_len == BL) exp_bc++;
            check_eq($sformatf("s3_wm_len_k%0d", k), run_at(base), exp_len);
            check_eq($sformatf("s3_wm_count_k%0d", k), gpif.burst_count, exp_bc);
        end

        // Stop with a partial FIFO: short packets, nShort only on the final word
        gpif.fx3_th0Ready = 1'b1;
        repeat (3) cyc();
        short_vals[0] = 37;
        short_vals[1] = int'($urandom_range(2, BL - 2));
        short_vals[2] = 1;
        short_vals[3] = 1500;
        foreach (short_vals[j]) begin
            v = short_vals[j];
            base = runs.size();
            if (gpif.capture_enable !== 1'b1) begin
                gpif.capture_enable = 1'b1;
                cyc();
                exp_bc = 0;
                check_eq("s4_count_cleared", gpif.burst_count, exp_bc);
            end
            set_level(v);
            cyc();
            gpif.capture_enable = 1'b0;
            wait_idle($sformatf("s4_idle_%0d", v));
            n = 0;
            while (v > 0) begin
                exp_len = (v > BL - 1) ? BL - 1 : v;
                check_eq($sformatf("s4_short_len_%0d_%0d", short_vals[j], n), run_at(base + n), exp_len);
                check_eq($sformatf("s4_short_pos_%0d_%0d", short_vals[j], n), short_of(base + n), exp_len);
                v -= exp_len;
                n++;
            end
            check_eq($sformatf("s4_run_count_%0d", short_vals[j]), runs.size(), base + n);
        end

        // Overflow during a gap is sticky across bursts until the next arming
        gpif.capture_enable = 1'b1;
        cyc();
        exp_bc = 0;
        check_eq("s5_nerror_initial", gpif.fx3_nError, 1);
        set_level(1500);
        fill = 1;
        gpif.fx3_th0Ready = 1'b0;
        base = runs.size();
        wait_runs(base + 1, "s5_first_burst");
        exp_bc++;
        gpif.fifo_full = 1'b1;
        cyc();
        gpif.fifo_full = 1'b0;
        cyc();
        check_eq("s5_nerror_set", gpif.fx3_nError, 0);
        for (int i = 0; i < 3; i++) begin
            wait_runs(base + 2 + i, "s5_burst");
            exp_bc++;
            check_eq($sformatf("s5_nerror_sticky_%0d", i), gpif.fx3_nError, 0);
            check_eq($sformatf("s5_count_%0d", i), gpif.burst_count, exp_bc);
        end
        fill = 0;
        gpif.fx3_th0Ready = 1'b1;
        gpif.capture_enable = 1'b0;
        wait_idle("s5_wind_down");
        check_eq("s5_nerror_after_stop", gpif.fx3_nError, 0);
        gpif.capture_enable = 1'b1;
        cyc();
        check_eq("s5_nerror_cleared", gpif.fx3_nError, 1);
        gpif.capture_enable = 1'b0;
        repeat (3) cyc();
        check_eq("s5_back_idle", gpif.busy, 0);
        gpif.fifo_full = 1'b1;
        cyc();
        gpif.fifo_full = 1'b0;
        cyc();
        check_eq("s5_idle_full_ignored", gpif.fx3_nError, 1);
        gpif.capture_enable = 1'b1;
        gpif.fifo_full = 1'b1;
        cyc();
        gpif.fifo_full = 1'b0;
        cyc();
        check_eq("s5_set_wins_on_arm", gpif.fx3_nError, 0);
        gpif.capture_enable = 1'b0;
        repeat (3) cyc();

        // Asynchronous reset mid-burst abandons the buffer; the following run is normal
        gpif.capture_enable = 1'b1;
        exp_bc = 0;
        set_level(1500);
        fill = 1;
        gpif.fx3_th0Ready = 1'b0;
        base = runs.size();
        wait_runs(base + 1, "s6_first_burst");
        exp_bc++;
        check_eq("s6_count_before_reset", gpif.burst_count, exp_bc);
        n = 0;
        while (run != 300 && n < BUDGET) begin
            cyc();
            n++;
        end
        check_eq("s6_reached_word_300", run, 300);
        fx3_reset = 1'b1;
        #1;
        check_eq("s6_async_nWrite", gpif.fx3_nWrite, 1);
        check_eq("s6_async_fifo_read", gpif.fifo_read, 0);
        check_eq("s6_async_count", gpif.burst_count, 0);
        check_eq("s6_async_busy", gpif.busy, 0);
        run = 0;
        short_at = 0;
        had_run = 0;
        @(negedge fx3_clock);
        fx3_reset = 1'b0;
        exp_bc = 0;
        base = runs.size();
        wait_runs(base + 1, "s6_post_reset_burst");
        exp_bc++;
        check_eq("s6_post_reset_len", run_at(base), BL);
        check_eq("s6_post_reset_count", gpif.burst_count, exp_bc);
        fill = 0;
        gpif.fx3_th0Ready = 1'b1;
        gpif.capture_enable = 1'b0;
        wait_idle("s6_wind_down");

        check_eq("read_matches_strobe", bad_pair, 0);
        check_eq("nshort_without_strobe", short_stray, 0);
        check_eq("strobe_on_empty_fifo", underflow, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
